// File: rtl/iob_iobuf_ctrl_pkg.sv
// iob_iobuf_ctrl_pkg: shared state encoding and width helper for the pad line controller
package iob_iobuf_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SHIFT,
        POST,
        DONE
    } state_e;

    function automatic int nbits_w(input int dw);
        return $clog2(dw) + 1;
    endfunction

endpackage

// File: rtl/iob_sync2.sv
// iob_sync2: two-flop synchronizer for an asynchronous pin, idles high like the released line
module iob_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) ff_q <= 2'b11;
        else     ff_q <= {ff_q[0], d_i};

    assign q_o = ff_q[1];

endmodule

// File: rtl/iob_iobuf_ctrl.sv
// iob_iobuf_ctrl: half-duplex bit-serial controller for one tri-state pad buffer
// with turnaround gaps, programmable bit period and LSB-first data.
module iob_iobuf_ctrl
    import iob_iobuf_ctrl_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DIV_W       = 16,
    parameter int TURN_CYCLES = 2,
    parameter int NBITS_W     = nbits_w(DATA_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               dir,
    input  logic [NBITS_W-1:0] nbits,
    input  logic [DIV_W-1:0]   div,
    input  logic [DATA_W-1:0]  wdata,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  rdata,
    output logic               pad_i,
    output logic               pad_oe,
    input  logic               pad_o
);

    localparam int TCW = TURN_CYCLES > 1 ? $clog2(TURN_CYCLES) : 1;
    localparam logic [TCW-1:0] TLAST = TCW'(TURN_CYCLES - 1);

    state_e             state_q;
    logic               dir_q;
    logic [NBITS_W-1:0] nb_q, bit_q, nb_d;
    logic [DIV_W-1:0]   div_q, cnt_q;
    logic [DATA_W-1:0]  wsh_q, shadow_q, rdata_q;
    logic [TCW-1:0]     tcnt_q;
    logic               pad_oe_q, pad_i_q, line_s;

    iob_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pad_o),
        .q_o (line_s)
    );

    assign nb_d   = nbits > NBITS_W'(DATA_W) ? NBITS_W'(DATA_W) : nbits;
    assign busy   = state_q == PRE || state_q == SHIFT || state_q == POST;
    assign done   = state_q == DONE;
    assign rdata  = rdata_q;
    assign pad_i  = pad_i_q;
    assign pad_oe = pad_oe_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q  <= IDLE;
            dir_q    <= 1'b0;
            nb_q     <= '0;
            bit_q    <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            wsh_q    <= '0;
            shadow_q <= '0;
            rdata_q  <= '0;
            tcnt_q   <= '0;
            pad_oe_q <= 1'b0;
            pad_i_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    // shadow fills from the MSB end, so shifting right aligns and zero-fills it
                    if (state_q == DONE && !dir_q && nb_q != '0)
                        rdata_q <= shadow_q >> (NBITS_W'(DATA_W) - nb_q);
                    state_q  <= IDLE;
                    pad_oe_q <= 1'b0;
                    pad_i_q  <= 1'b1;
                    if (start) begin
                        dir_q  <= dir;
                        nb_q   <= nb_d;
                        div_q  <= div;
                        wsh_q  <= wdata;
                        tcnt_q <= '0;
                        cnt_q  <= '0;
                        bit_q  <= '0;
                        if (nb_d == '0) state_q <= DONE;
                        else if (TURN_CYCLES != 0) begin
                            state_q  <= PRE;
                            pad_oe_q <= dir;
                        end else begin
                            state_q  <= SHIFT;
                            pad_oe_q <= dir;
                            pad_i_q  <= !dir || wdata[0];
                        end
                    end
                end
                PRE:
                    if (tcnt_q == TLAST) begin
                        state_q <= SHIFT;
                        pad_i_q <= !dir_q || wsh_q[0];
                    end else tcnt_q <= tcnt_q + 1'b1;
                SHIFT: begin
                    if (!dir_q && cnt_q == (div_q >> 1))
                        shadow_q <= {line_s, shadow_q[DATA_W-1:1]};
                    if (cnt_q != div_q) cnt_q <= cnt_q + 1'b1;
                    else if (bit_q != nb_q - 1'b1) begin
                        cnt_q   <= '0;
                        bit_q   <= bit_q + 1'b1;
                        wsh_q   <= wsh_q >> 1;
                        pad_i_q <= !dir_q || wsh_q[1];
                    end else begin
                        pad_oe_q <= 1'b0;
                        pad_i_q  <= 1'b1;
                        tcnt_q   <= '0;
                        state_q  <= TURN_CYCLES != 0 ? POST : DONE;
                    end
                end
                POST:
                    if (tcnt_q == TLAST) state_q <= DONE;
                    else tcnt_q <= tcnt_q + 1'b1;
                default: state_q <= IDLE;
            endcase
        end

endmodule

// File: tb/tb_iob_iobuf_ctrl.sv
// tb_iob_iobuf_ctrl: directed vector table plus corner-case sequences for iob_iobuf_ctrl
module tb_iob_iobuf_ctrl;

    localparam int T = 2;

    typedef struct {
        logic        dir;
        logic [3:0]  nb;
        logic [15:0] dv;
        logic [7:0]  wd;
        logic [7:0]  line;
        logic [7:0]  exp_rd;
        int          exp_done;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, dir = 1'b0, pad_o = 1'b1;
    logic [3:0]  nbits = '0;
    logic [15:0] div = '0;
    logic [7:0]  wdata = '0;
    logic        busy, done, pad_i, pad_oe;
    logic [7:0]  rdata;
    int          n_cmp = 0, n_bad = 0;
    vec_t        vt[9];

    iob_iobuf_ctrl #(.DATA_W(8), .DIV_W(16), .TURN_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .nbits(nbits), .div(div),
        .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .pad_i(pad_i),
        .pad_oe(pad_oe), .pad_o(pad_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // line level the bench expects the DUT to see in cycle c of a read
    function automatic logic line_bit(input vec_t v, input int c);
        int nbc = v.nb > 8 ? 8 : int'(v.nb);
        int per = int'(v.dv) + 1;
        if (!v.dir && c > T && c <= T + nbc * per) return v.line[(c - T - 1) / per];
        return 1'b1;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int nbc = v.nb > 8 ? 8 : int'(v.nb);
        int per = int'(v.dv) + 1;
        int shend = T + nbc * per;
        logic [3:0] exp;
        @(negedge clk);
        dir = v.dir; nbits = v.nb; div = v.dv; wdata = v.wd; start = 1'b1;
        pad_o = line_bit(v, 2);
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= v.exp_done + 1; c++) begin
            @(negedge clk);
            pad_o = line_bit(v, c + 2);
            exp[3] = c < v.exp_done;
            exp[2] = c == v.exp_done;
            exp[1] = v.dir && c <= shend && c < v.exp_done;
            exp[0] = (v.dir && c > T && c <= shend && c < v.exp_done) ? v.wd[(c - T - 1) / per] : 1'b1;
            chk($sformatf("vec%0d cyc%0d busy/done/oe/pad_i", idx, c), {busy, done, pad_oe, pad_i}, exp);
        end
        chk($sformatf("vec%0d rdata", idx), rdata, v.exp_rd);
    endtask

    initial begin
        int ndone, dcyc;
        vt[0] = '{1'b1, 4'd8,  16'd3, 8'hA5, 8'h00, 8'h00, 37};
        vt[1] = '{1'b0, 4'd8,  16'd3, 8'h00, 8'h3C, 8'h3C, 37};
        vt[2] = '{1'b0, 4'd8,  16'd0, 8'h00, 8'hFF, 8'hFF, 13};
        vt[3] = '{1'b0, 4'd3,  16'd2, 8'h00, 8'h05, 8'h05, 14};
        vt[4] = '{1'b1, 4'd0,  16'd3, 8'hFF, 8'h00, 8'h05, 1};
        vt[5] = '{1'b1, 4'd12, 16'd1, 8'h3C, 8'h00, 8'h05, 21};
        vt[6] = '{1'b0, 4'd5,  16'd0, 8'h00, 8'h1A, 8'h1A, 10};
        vt[7] = '{1'b1, 4'd1,  16'd0, 8'h01, 8'h00, 8'h1A, 6};
        vt[8] = '{1'b0, 4'd4,  16'd1, 8'h00, 8'hF6, 8'h06, 13};

        repeat (2) @(negedge clk);
        chk("reset busy/done/oe/pad_i", {busy, done, pad_oe, pad_i}, 4'b0001);
        chk("reset rdata", rdata, 8'h00);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vt[i], i);

        // a start request in the middle of a write must be ignored
        @(negedge clk);
        dir = 1'b1; nbits = 4'd8; div = 16'd3; wdata = 8'h5A; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0; dcyc = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (done) begin ndone++; dcyc = c; end
            if (c == 10) begin start = 1'b1; dir = 1'b0; nbits = 4'd1; end
            if (c == 11) start = 1'b0;
            if (c == 20) chk("ignored start oe", pad_oe, 1'b1);
        end
        chk("ignored start done count", ndone, 1);
        chk("ignored start done cycle", dcyc, 37);

        // start in the DONE cycle is accepted
        @(negedge clk);
        dir = 1'b1; nbits = 4'd1; div = 16'd0; wdata = 8'h01; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        chk("back-to-back first done", done, 1'b1);
        dir = 1'b0; nbits = 4'd2; div = 16'd0; start = 1'b1; pad_o = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("back-to-back busy/done", {busy, done}, 2'b10);
        dcyc = 0;
        for (int c = 2; c <= 20; c++) begin
            @(negedge clk);
            if (done && dcyc == 0) dcyc = c;
        end
        chk("back-to-back second done cycle", dcyc, 7);
        chk("back-to-back rdata", rdata, 8'h03);

        // asynchronous reset in the middle of a write
        @(negedge clk);
        dir = 1'b1; nbits = 4'd8; div = 16'd3; wdata = 8'hFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre-reset oe", pad_oe, 1'b1);
        #1 rst = 1'b1;
        #1 chk("async reset busy/done/oe/pad_i", {busy, done, pad_oe, pad_i}, 4'b0001);
        chk("async reset rdata", rdata, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (done || busy || pad_oe) ndone++;
        end
        chk("after reset no activity", ndone, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/iob_iobuf_ctrl.md
Name: iob_iobuf_ctrl

Overview:
- Half-duplex, bit-serial line controller that sequences one tri-state pad buffer: drives its data input and output-enable, and samples its output.
- A host issues a write or read transaction of up to DATA_W bits. The block inserts bus-turnaround gaps, times each bit with a programmable divider, and returns read data.
- Sits between a register/host interface and the pad buffer instance on a single shared wire.

Parameters:
- DATA_W, 8, maximum bits per transaction and width of wdata/rdata.
- DIV_W, 16, width of the bit-period divider input.
- TURN_CYCLES, 2, clock cycles of turnaround before and after each transaction; 0 is legal and removes the gaps.
- NBITS_W, $clog2(DATA_W)+1, width of nbits (derived).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  transaction request; accepted only when busy=0.
- dir  in  1  1=write (drive line), 0=read (sample line).
- nbits  in  NBITS_W  bit count; 0=null transaction; values >DATA_W are clamped to DATA_W.
- div  in  DIV_W  bit period = div+1 clk cycles.
- wdata  in  DATA_W  write data, sent LSB first.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  last read result.
- pad_i  out  1  to buffer data input.
- pad_oe  out  1  to buffer output enable.
- pad_o  in  1  from buffer output (asynchronous pin value).

Behaviour:
- Reset (async, immediate): state=IDLE, pad_oe=0, pad_i=1, busy=0, done=0, rdata=0, all counters 0.
- Accept: on the clk edge where start=1 and busy=0, latch dir, clamped nbits, div and wdata. busy=1 from the next cycle. Inputs are ignored while busy.
- States: IDLE -> PRE -> SHIFT -> POST -> DONE -> IDLE.
  - PRE: TURN_CYCLES cycles.
  - SHIFT: nbits*(div+1) cycles.
  - POST: TURN_CYCLES cycles.
  - DONE: 1 cycle, with done=1 and busy=0. A new start is accepted in the DONE cycle.
- nbits=0: IDLE -> DONE directly. done is asserted the cycle after accept; pad_oe stays 0; rdata is unchanged.
- Write:
  - pad_oe=1 in PRE and SHIFT; pad_i=1 in PRE.
  - In SHIFT, pad_i = wdata[k] for bit k, held div+1 cycles, k=0..nbits-1.
  - In POST, pad_oe=0 and pad_i=1.
  - rdata is unchanged.
- Read:
  - pad_oe=0 throughout.
  - pad_o passes through a 2-flop synchronizer (2-cycle latency).
  - Bit counter cnt runs 0..div within each bit period. At cnt==div>>1, the synchronized value is stored into shadow bit k.
  - In the DONE cycle, rdata <= shadow, with bits >= nbits set to 0.
- Timing, cycles numbered from accept edge E0:
  - PRE occupies cycles 1..T (T=TURN_CYCLES).
  - Bit k occupies cycles T+1+k*(div+1) .. T+(k+1)*(div+1).
  - POST follows SHIFT; DONE follows POST.
- div=0: one cycle per bit; in read mode the sample point is cnt=0.
- Reset mid-transaction: return to reset state immediately. No done pulse is produced; rdata is cleared.
- pad_oe and pad_i are registered outputs (glitch-free).

Decomposition:
- Shared package `iob_iobuf_ctrl_pkg`: state encoding localparams (IDLE, PRE, SHIFT, POST, DONE), plus NBITS_W derivation.
- One sub-module: `iob_sync2`, a 2-flop synchronizer with async active-high reset and reset value 1, used for pad_o.
- Divider counter, bit counter and shift registers stay inline.

Test Plan:
- Write, DATA_W=8, TURN=2, div=3, nbits=8, wdata=0xA5:
  - pad_oe=1 cycles 1..34, pad_i=1 cycles 1..2.
  - Bits 1,0,1,0,0,1,0,1 in 4-cycle slots from cycle 3.
  - pad_oe=0 cycles 35..36; done=1 at cycle 37 only; busy=1 cycles 1..36.
- Read, div=3, nbits=8: bench drives pad_o with 0x3C LSB first, each bit stable across its slot shifted +2 cycles for the synchronizer -> pad_oe never 1; rdata=0x3C at done (cycle 37).
- Read, nbits=3, line bits 1,0,1 with rdata previously 0xFF -> rdata=0x05 after done.
- nbits=0, dir=1 -> done=1 at cycle 1, pad_oe stays 0, rdata unchanged; nbits=12 with DATA_W=8 behaves as nbits=8.
- start pulsed at cycle 10 of an active write -> ignored; exactly one done pulse. start asserted in the DONE cycle -> new transaction accepted, busy=1 next cycle.
- rst asserted asynchronously mid-SHIFT of a write -> pad_oe=0 before the next clk edge; busy=0, rdata=0; no done pulse ever follows.
